// File: rtl/bp_verify_queue_pkg.sv
// Shared types for the branch-prediction verify queue: queue entry, FSM states, RV32I opcodes.
package bp_verify_queue_pkg;

  localparam logic [6:0] br_opcode   = 7'b1100011;
  localparam logic [6:0] jal_opcode  = 7'b1101111;
  localparam logic [6:0] jalr_opcode = 7'b1100111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pred_next;
  } bpq_entry_t;

  typedef enum logic [0:0] {
    BPQ_RUN   = 1'b0,
    BPQ_FLUSH = 1'b1
  } bpq_state_t;

endpackage

// File: rtl/bp_verify_queue_if.sv
// Fetch/commit-side bundle of the verify queue. Statistics outputs exist only when
// BP_VERIFY_STATS_EN is defined.
interface bp_verify_queue_if;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pred_next;
  logic        fetch_ready;
  logic        rob_pop;
  logic [31:0] commit_pc;
  logic [31:0] commit_pc_next;
  logic [6:0]  commit_opcode;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        mispred_is_br;
  logic        err;
`ifdef BP_VERIFY_STATS_EN
  logic [31:0] stat_commits;
  logic [31:0] stat_mispred;
  logic [31:0] stat_mispred_br;
  logic [31:0] stat_mispred_j;

  modport master (
    output fetch_valid, fetch_pc, fetch_pred_next, rob_pop,
           commit_pc, commit_pc_next, commit_opcode,
    input  fetch_ready, flush, redirect_pc, mispred_is_br, err,
           stat_commits, stat_mispred, stat_mispred_br, stat_mispred_j
  );
  modport slave (
    input  fetch_valid, fetch_pc, fetch_pred_next, rob_pop,
           commit_pc, commit_pc_next, commit_opcode,
    output fetch_ready, flush, redirect_pc, mispred_is_br, err,
           stat_commits, stat_mispred, stat_mispred_br, stat_mispred_j
  );
`else
  modport master (
    output fetch_valid, fetch_pc, fetch_pred_next, rob_pop,
           commit_pc, commit_pc_next, commit_opcode,
    input  fetch_ready, flush, redirect_pc, mispred_is_br, err
  );
  modport slave (
    input  fetch_valid, fetch_pc, fetch_pred_next, rob_pop,
           commit_pc, commit_pc_next, commit_opcode,
    output fetch_ready, flush, redirect_pc, mispred_is_br, err
  );
`endif
endinterface

// File: rtl/bp_verify_queue_fifo.sv
// Circular buffer of prediction records with push, pop and a whole-queue clear.
module bp_verify_queue_fifo
  import bp_verify_queue_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  bpq_entry_t wdata,
  output bpq_entry_t rdata,
  output logic       full,
  output logic       empty
);
  localparam logic [DEPTH_LOG2:0] CAPACITY = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;
  logic [DEPTH_LOG2:0]   count;
  bpq_entry_t            mem [2 ** DEPTH_LOG2];
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CAPACITY);
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[head];

  // NOTE: pointers and count are reset; the storage array is not, since an entry is
  // only ever read after being written and a reset on the array would block RAM mapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= wdata;
  end

endmodule

// File: rtl/bp_verify_queue.sv
// Prediction verify queue: records fetch predictions and checks them at commit, raising
// a one-cycle flush/redirect on a mispredict. Optional counters under BP_VERIFY_STATS_EN.
module bp_verify_queue
  import bp_verify_queue_pkg::*;
#(
  parameter int PQ_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  bp_verify_queue_if.slave bus
);
  localparam logic [0:0] ST_RUN   = BPQ_RUN;
  localparam logic [0:0] ST_FLUSH = BPQ_FLUSH;

  logic [0:0]  state;
  logic        flush_q;
  logic [31:0] redirect_q;
  logic        is_br_q;
  logic        err_q;

  bpq_entry_t  head_entry;
  bpq_entry_t  push_entry;
  logic        full;
  logic        empty;
  logic        in_run;
  logic        pop_ok;
  logic        underflow;
  logic        desync;
  logic        mispred;
  logic        push;

  assign in_run     = (state == ST_RUN);
  assign pop_ok     = in_run && bus.rob_pop && !empty;
  assign underflow  = in_run && bus.rob_pop && empty;
  assign desync     = pop_ok && (bus.commit_pc != head_entry.pc);
  assign mispred    = pop_ok && (bus.commit_pc_next != head_entry.pred_next);
  // fetch_ready looks only at registered state; a same-cycle pop never frees a slot early.
  assign bus.fetch_ready = in_run && !full;
  assign push       = bus.fetch_valid && bus.fetch_ready && !mispred;
  assign push_entry = '{pc: bus.fetch_pc, pred_next: bus.fetch_pred_next};

  bp_verify_queue_fifo #(.DEPTH_LOG2(PQ_DEPTH)) u_bpq_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop_ok),
    .clear (mispred),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      is_br_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (state == ST_FLUSH) begin
        state   <= ST_RUN;
        flush_q <= 1'b0;
      end else if (mispred) begin
        state      <= ST_FLUSH;
        flush_q    <= 1'b1;
        redirect_q <= bus.commit_pc_next;
        is_br_q    <= (bus.commit_opcode == br_opcode);
      end
      if (underflow || desync) err_q <= 1'b1;
    end
  end

  assign bus.flush         = flush_q;
  assign bus.redirect_pc   = redirect_q;
  assign bus.mispred_is_br = is_br_q;
  assign bus.err           = err_q;

`ifdef BP_VERIFY_STATS_EN
  logic [31:0] commits_q, mispred_q, mispred_br_q, mispred_j_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commits_q    <= '0;
      mispred_q    <= '0;
      mispred_br_q <= '0;
      mispred_j_q  <= '0;
    end else begin
      if (pop_ok) commits_q <= commits_q + 1'b1;
      if (mispred) begin
        mispred_q <= mispred_q + 1'b1;
        if (bus.commit_opcode == br_opcode) mispred_br_q <= mispred_br_q + 1'b1;
        else                                mispred_j_q  <= mispred_j_q + 1'b1;
      end
    end
  end

  assign bus.stat_commits    = commits_q;
  assign bus.stat_mispred    = mispred_q;
  assign bus.stat_mispred_br = mispred_br_q;
  assign bus.stat_mispred_j  = mispred_j_q;
`endif

endmodule
